// File: rtl/aibcr3aux_osc_freq_mon.sv
// ---------------------------------------------------------------------------
// aibcr3aux_osc_freq_mon
//
// Frequency monitor controller for the aux oscillator. It clears the external
// 6-bit counter, enables it for a programmed window of reference clocks, lets
// it settle, then captures the count and compares it against an inclusive
// low/high threshold pair. It runs single-shot or back-to-back (cont_mode).
//
// Parameters:
//   WIN_W  - width of the window length field
//   SETTLE - reference cycles between enable removal and capture (>= 2)
//
// Ports:
//   clk, reset_n          - reference clock, async active-low reset
//   start                 - request a measurement (only looked at in IDLE)
//   cont_mode             - re-arm automatically after every capture
//   abort                 - synchronous abort back to IDLE, no done
//   win_len               - window length in clk cycles (0 acts as 1)
//   thr_lo, thr_hi        - inclusive count limits
//   cnt_bin               - oscillator count, quasi-static when sampled
//   cnt_en, cnt_rstb      - counter enable / active-low clear
//   meas_val, in_range    - last captured count and its verdict
//   done                  - one-cycle pulse when meas_val/in_range update
//   busy                  - high whenever the FSM is not IDLE
//
// Optional feature (macro AIBCR3AUX_FMON_STICKY_FAIL_EN):
//   fail_sticky - set by any out-of-range capture, cleared by reset_n or by
//                 an accepted start; survives abort and continuous iterations.
// ---------------------------------------------------------------------------
module aibcr3aux_osc_freq_mon #(
  parameter int unsigned WIN_W  = 8,
  parameter int unsigned SETTLE = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             cont_mode,
  input  logic             abort,
  input  logic [WIN_W-1:0] win_len,
  input  logic [5:0]       thr_lo,
  input  logic [5:0]       thr_hi,
  input  logic [5:0]       cnt_bin,
  output logic             cnt_en,
  output logic             cnt_rstb,
  output logic [5:0]       meas_val,
  output logic             in_range,
  output logic             done,
  output logic             busy
`ifdef AIBCR3AUX_FMON_STICKY_FAIL_EN
  ,
  output logic             fail_sticky
`endif
);

  // Phase timer must hold both the window length and the settle length.
  localparam int unsigned SettleW = (SETTLE > 2) ? $clog2(SETTLE) : 1;
  localparam int unsigned TmrW    = (WIN_W > SettleW) ? WIN_W : SettleW;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StClr     = 3'd1,
    StCount   = 3'd2,
    StSettle  = 3'd3,
    StCapture = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [TmrW-1:0]  timer_q, timer_d;
  logic [WIN_W-1:0] win_len_q, win_len_d;
  logic [5:0]       thr_lo_q, thr_lo_d;
  logic [5:0]       thr_hi_q, thr_hi_d;
  logic [5:0]       meas_val_q, meas_val_d;
  logic             in_range_q, in_range_d;
  logic             done_q, done_d;
  logic             cnt_en_q, cnt_en_d;
  logic             cnt_rstb_q, cnt_rstb_d;
  logic             busy_q, busy_d;

  logic             load_cfg;
  logic             capture;
  logic             cmp_ok;
  logic [WIN_W-1:0] win_eff;

  // A zero-length window still enables the counter for one cycle.
  assign win_eff = (win_len_q == '0) ? WIN_W'(1) : win_len_q;

  // Inverted thresholds (lo > hi) can never satisfy both bounds.
  assign cmp_ok  = (cnt_bin >= thr_lo_q) && (cnt_bin <= thr_hi_q);

  // Abort suppresses the capture even if it lands on the CAPTURE cycle.
  assign capture = (state_q == StCapture) && !abort;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    load_cfg = 1'b0;
    if (abort) begin
      state_d = StIdle;
      timer_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d  = StClr;
            timer_d  = TmrW'(1);
            load_cfg = 1'b1;
          end
        end
        StClr: begin
          if (timer_q == '0) begin
            state_d = StCount;
            timer_d = TmrW'(win_eff) - TmrW'(1);
          end else begin
            timer_d = timer_q - TmrW'(1);
          end
        end
        StCount: begin
          if (timer_q == '0) begin
            state_d = StSettle;
            timer_d = TmrW'(SETTLE - 1);
          end else begin
            timer_d = timer_q - TmrW'(1);
          end
        end
        StSettle: begin
          if (timer_q == '0) begin
            state_d = StCapture;
          end else begin
            timer_d = timer_q - TmrW'(1);
          end
        end
        StCapture: begin
          if (cont_mode) begin
            state_d  = StClr;
            timer_d  = TmrW'(1);
            load_cfg = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
          timer_d = '0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output logic: outputs are registered from the next state so they line up
  // with state_q and have no combinational path from the inputs.
  // -------------------------------------------------------------------------
  always_comb begin
    cnt_en_d   = (state_d == StCount);
    cnt_rstb_d = (state_d != StClr);
    busy_d     = (state_d != StIdle);
    done_d     = capture;
    meas_val_d = capture ? cnt_bin : meas_val_q;
    in_range_d = capture ? cmp_ok  : in_range_q;
  end

  // Configuration is frozen on every entry to CLR.
  always_comb begin
    win_len_d = win_len_q;
    thr_lo_d  = thr_lo_q;
    thr_hi_d  = thr_hi_q;
    if (load_cfg) begin
      win_len_d = win_len;
      thr_lo_d  = thr_lo;
      thr_hi_d  = thr_hi;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_en_q   <= 1'b0;
      cnt_rstb_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      meas_val_q <= 6'h00;
      in_range_q <= 1'b0;
      win_len_q  <= '0;
      thr_lo_q   <= 6'h00;
      thr_hi_q   <= 6'h00;
    end else begin
      cnt_en_q   <= cnt_en_d;
      cnt_rstb_q <= cnt_rstb_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      meas_val_q <= meas_val_d;
      in_range_q <= in_range_d;
      win_len_q  <= win_len_d;
      thr_lo_q   <= thr_lo_d;
      thr_hi_q   <= thr_hi_d;
    end
  end

  assign cnt_en   = cnt_en_q;
  assign cnt_rstb = cnt_rstb_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign meas_val = meas_val_q;
  assign in_range = in_range_q;

`ifdef AIBCR3AUX_FMON_STICKY_FAIL_EN
  logic fail_sticky_q, fail_sticky_d;

  always_comb begin
    fail_sticky_d = fail_sticky_q;
    if ((state_q == StIdle) && start && !abort) begin
      fail_sticky_d = 1'b0;
    end else if (capture && !cmp_ok) begin
      fail_sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fail_sticky_q <= 1'b0;
    end else begin
      fail_sticky_q <= fail_sticky_d;
    end
  end

  assign fail_sticky = fail_sticky_q;
`endif

endmodule
